// File: rtl/mii_tx.sv
// MII nibble transmitter: wraps a byte stream with preamble/SFD, optional zero pad,
// CRC-32 FCS and an inter-frame gap; aborts with tx_er when the source underruns.
module mii_tx #(
    parameter int IFG_NIBBLES = 24,
    parameter bit PAD_ENABLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mii_tx_en,
    output logic [3:0] mii_txd,
    output logic       mii_tx_er,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [10:0] MIN_BYTES = 11'd60;

    state_t      state_q, state_d;
    logic        hi_q, hi_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [10:0] bcnt_q, bcnt_d;
    logic [15:0] ncnt_q, ncnt_d;
    logic [31:0] crc_q, crc_d;
    logic        tx_en_q, tx_en_d;
    logic [3:0]  txd_q, txd_d;
    logic        tx_er_q, tx_er_d;
    logic        done_q, done_d;
    logic        und_q, und_d;

    function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ n[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // state_q describes the nibble currently on the wire; outputs are registered
    // from the next state so they line up with it.
    assign tx_ready = (state_q == S_IDLE) || (state_q == S_DATA && hi_q && !last_q);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        byte_d  = byte_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        ncnt_d  = ncnt_q;
        crc_d   = crc_q;
        done_d  = 1'b0;
        und_d   = 1'b0;
        tx_en_d = 1'b0;
        txd_d   = 4'h0;
        tx_er_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_PREAMBLE;
                    byte_d  = tx_data;
                    last_d  = tx_last;
                    bcnt_d  = 11'd1;
                    ncnt_d  = 16'd0;
                    crc_d   = 32'hFFFFFFFF;
                end
            end
            S_PREAMBLE: begin
                if (ncnt_q == 16'd14) state_d = S_SFD;
                else                  ncnt_d  = ncnt_q + 16'd1;
            end
            S_SFD: begin
                state_d = S_DATA;
                hi_d    = 1'b0;
            end
            S_DATA, S_PAD: begin
                if (!hi_q) begin
                    hi_d = 1'b1;
                end else if (!last_q) begin
                    if (tx_valid) begin
                        byte_d = tx_data;
                        last_d = tx_last;
                        bcnt_d = sat_inc(bcnt_q);
                        hi_d   = 1'b0;
                    end else begin
                        state_d = S_ABORT;
                        und_d   = 1'b1;
                    end
                end else if (PAD_ENABLE && bcnt_q < MIN_BYTES) begin
                    state_d = S_PAD;
                    byte_d  = 8'h00;
                    bcnt_d  = sat_inc(bcnt_q);
                    hi_d    = 1'b0;
                end else begin
                    state_d = S_FCS;
                    ncnt_d  = 16'd0;
                end
            end
            S_FCS: begin
                if (ncnt_q == 16'd7) begin
                    state_d = S_IFG;
                    ncnt_d  = 16'd0;
                    done_d  = 1'b1;
                end else begin
                    ncnt_d = ncnt_q + 16'd1;
                end
            end
            S_ABORT: begin
                state_d = S_IFG;
                ncnt_d  = 16'd0;
            end
            S_IFG: begin
                if (int'(ncnt_q) + 1 >= IFG_NIBBLES) state_d = S_IDLE;
                else                                 ncnt_d  = ncnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_PREAMBLE: begin tx_en_d = 1'b1; txd_d = 4'h5; end
            S_SFD:      begin tx_en_d = 1'b1; txd_d = 4'hD; end
            S_DATA, S_PAD: begin
                tx_en_d = 1'b1;
                txd_d   = hi_d ? byte_d[7:4] : byte_d[3:0];
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = ~crc_q[{ncnt_d[2:0], 2'b00} +: 4];
            end
            S_ABORT: begin tx_en_d = 1'b1; tx_er_d = 1'b1; end
            default: ;
        endcase

        // CRC tracks exactly the nibbles that go out as data or pad
        if (state_d == S_DATA || state_d == S_PAD) crc_d = crc_nibble(crc_q, txd_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= 1'b0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            bcnt_q  <= 11'd0;
            ncnt_q  <= 16'd0;
            crc_q   <= 32'h0;
            tx_en_q <= 1'b0;
            txd_q   <= 4'h0;
            tx_er_q <= 1'b0;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            ncnt_q  <= ncnt_d;
            crc_q   <= crc_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            tx_er_q <= tx_er_d;
            done_q  <= done_d;
            und_q   <= und_d;
        end
    end

    assign mii_tx_en  = tx_en_q;
    assign mii_txd    = txd_q;
    assign mii_tx_er  = tx_er_q;
    assign frame_done = done_q;
    assign underrun   = und_q;
endmodule

// File: tb/tb_mii_tx.sv
// Bench for mii_tx: one unpadded and one padded instance, randomized frames
// checked against a byte-level reference model of the wire nibble stream.
module tb_mii_tx;
    localparam int IFG = 24;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst_n;
    logic [7:0] din [2];
    logic       vin [2];
    logic       lin [2];
    logic       rdy [2];
    logic       en  [2];
    logic [3:0] txd [2];
    logic       er  [2];
    logic       done[2];
    logic       und [2];

    mii_tx #(.IFG_NIBBLES(IFG), .PAD_ENABLE(1'b0)) u_nopad (
        .clk(clk), .rst_n(rst_n), .tx_data(din[0]), .tx_valid(vin[0]), .tx_last(lin[0]),
        .tx_ready(rdy[0]), .mii_tx_en(en[0]), .mii_txd(txd[0]), .mii_tx_er(er[0]),
        .frame_done(done[0]), .underrun(und[0]));

    mii_tx #(.IFG_NIBBLES(IFG), .PAD_ENABLE(1'b1)) u_pad (
        .clk(clk), .rst_n(rst_n), .tx_data(din[1]), .tx_valid(vin[1]), .tx_last(lin[1]),
        .tx_ready(rdy[1]), .mii_tx_en(en[1]), .mii_txd(txd[1]), .mii_tx_er(er[1]),
        .frame_done(done[1]), .underrun(und[1]));

    int n_checks = 0;
    int n_pass   = 0;
    int tmo      = 0;

    // Wire monitor: every tx_en-high run becomes one captured frame
    logic [3:0] nib_mem [2][16384];
    int wp[2]       = '{0, 0};
    int nfr[2]      = '{0, 0};
    int ngap[2]     = '{0, 0};
    int lowrun[2]   = '{0, 0};
    int cur_start[2]= '{0, 0};
    int cur_er[2]   = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int und_cnt[2]  = '{0, 0};
    logic prev_en[2] = '{1'b0, 1'b0};
    int fstart[2][64];
    int flen[2][64];
    int fer[2][64];
    int gap[2][64];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en[d] === 1'b1) begin
                if (!prev_en[d]) begin
                    cur_start[d] = wp[d];
                    cur_er[d] = 0;
                    if (nfr[d] > 0 && ngap[d] < 64) begin
                        gap[d][ngap[d]] = lowrun[d];
                        ngap[d]++;
                    end
                end
                if (wp[d] < 16384) begin
                    nib_mem[d][wp[d]] = txd[d];
                    wp[d]++;
                end
                if (er[d] === 1'b1) cur_er[d]++;
                prev_en[d] = 1'b1;
            end else begin
                if (prev_en[d]) begin
                    if (nfr[d] < 64) begin
                        fstart[d][nfr[d]] = cur_start[d];
                        flen[d][nfr[d]]   = wp[d] - cur_start[d];
                        fer[d][nfr[d]]    = cur_er[d];
                        nfr[d]++;
                    end
                    lowrun[d] = 1;
                end else begin
                    lowrun[d]++;
                end
                prev_en[d] = 1'b0;
            end
            if (done[d] === 1'b1) done_cnt[d]++;
            if (und[d] === 1'b1) und_cnt[d]++;
        end
    end

    logic [7:0] fr[$];
    logic [3:0] exp_q[$];

    // Reference: whole-frame view built from bytes with a byte-wise CRC-32
    task automatic build_expected(input bit pad);
        logic [7:0]  b[$];
        logic [31:0] crc;
        b = fr;
        if (pad) while (b.size() < 60) b.push_back(8'h00);
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        crc = 32'hFFFFFFFF;
        foreach (b[i]) begin
            exp_q.push_back(b[i][3:0]);
            exp_q.push_back(b[i][7:4]);
            crc = crc ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(crc[8*k +: 4]);
            exp_q.push_back(crc[8*k+4 +: 4]);
        end
    endtask

    function automatic int frame_diff(input int d, input int idx);
        int n;
        n = (flen[d][idx] < exp_q.size()) ? flen[d][idx] : exp_q.size();
        for (int i = 0; i < n; i++)
            if (nib_mem[d][fstart[d][idx] + i] !== exp_q[i]) return i;
        if (flen[d][idx] != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic rand_frame(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    endtask

    task automatic send_frame(input int d, input int drop_at);
        int   cyc;
        logic acc;
        for (int i = 0; i < fr.size(); i++) begin
            if (i == drop_at) begin
                vin[d] = 1'b0;
                return;
            end
            vin[d] = 1'b1;
            din[d] = fr[i];
            lin[d] = (drop_at < 0) && (i == fr.size() - 1);
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 400) begin
                @(negedge clk);
                acc = (rdy[d] === 1'b1);
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                tmo++;
                vin[d] = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_frames(input int d, input int target);
        int c = 0;
        while (nfr[d] < target && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (nfr[d] < target) tmo++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vin[d] = 1'b0; lin[d] = 1'b0; din[d] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({en[d], txd[d], er[d], done[d], und[d]} !== 8'h00)
                $display("FAIL reset_outputs dut%0d: got en=%b txd=%h er=%b done=%b und=%b, want all 0",
                         d, en[d], txd[d], er[d], done[d], und[d]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rdy[d] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b, want 1", d, rdy[d]);
            else n_pass++;
        end
        $display("reset released");
    endtask

    task automatic test_crc_vector;
        logic [3:0] fcs_ref[8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        int idx, d0, bad, df;
        fr.delete();
        for (int i = 1; i <= 9; i++) fr.push_back(8'(8'h30 + i));
        idx = nfr[0];
        d0 = done_cnt[0];
        send_frame(0, -1);
        vin[0] = 1'b0;
        wait_frames(0, idx + 1);
        build_expected(1'b0);
        $display("frame dut0 \"123456789\" len=%0d", flen[0][idx]);
        n_checks++;
        if (flen[0][idx] != 42) $display("FAIL crc_vec_len: got %0d, want 42", flen[0][idx]);
        else n_pass++;
        df = frame_diff(0, idx);
        n_checks++;
        if (df != -1) $display("FAIL crc_vec_stream: nibble %0d got %h, want %h", df,
                               nib_mem[0][fstart[0][idx] + df], exp_q[df]);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (nib_mem[0][fstart[0][idx] + 34 + k] !== fcs_ref[k]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL crc_vec_fcs: %0d FCS nibbles differ from 6293 4FBC", bad);
        else n_pass++;
        n_checks++;
        if (done_cnt[0] - d0 != 1) $display("FAIL crc_vec_done: got %0d pulses, want 1", done_cnt[0] - d0);
        else n_pass++;
        n_checks++;
        if (fer[0][idx] != 0) $display("FAIL crc_vec_er: got %0d er cycles, want 0", fer[0][idx]);
        else n_pass++;
    endtask

    task automatic test_pad;
        int idx, df;
        rand_frame(14);
        idx = nfr[1];
        send_frame(1, -1);
        vin[1] = 1'b0;
        wait_frames(1, idx + 1);
        build_expected(1'b1);
        $display("frame dut1 14 bytes len=%0d", flen[1][idx]);
        n_checks++;
        if (flen[1][idx] != 144) $display("FAIL pad_len: got %0d, want 144", flen[1][idx]);
        else n_pass++;
        df = frame_diff(1, idx);
        n_checks++;
        if (df != -1) $display("FAIL pad_stream: nibble %0d got %h, want %h", df,
                               nib_mem[1][fstart[1][idx] + df], exp_q[df]);
        else n_pass++;
    endtask

    task automatic test_single_byte;
        int idx, d0, df;
        fr.delete();
        fr.push_back(8'hAB);
        idx = nfr[1];
        d0 = done_cnt[1];
        send_frame(1, -1);
        vin[1] = 1'b0;
        wait_frames(1, idx + 1);
        build_expected(1'b1);
        $display("frame dut1 single 0xAB len=%0d", flen[1][idx]);
        n_checks++;
        if ({nib_mem[1][fstart[1][idx] + 16], nib_mem[1][fstart[1][idx] + 17]} !== 8'hBA)
            $display("FAIL single_nibbles: got %h%h, want BA", nib_mem[1][fstart[1][idx] + 16],
                     nib_mem[1][fstart[1][idx] + 17]);
        else n_pass++;
        n_checks++;
        if (flen[1][idx] != 144) $display("FAIL single_len: got %0d, want 144", flen[1][idx]);
        else n_pass++;
        df = frame_diff(1, idx);
        n_checks++;
        if (df != -1) $display("FAIL single_stream: nibble %0d got %h, want %h", df,
                               nib_mem[1][fstart[1][idx] + df], exp_q[df]);
        else n_pass++;
        n_checks++;
        if (done_cnt[1] - d0 != 1) $display("FAIL single_done: got %0d pulses, want 1", done_cnt[1] - d0);
        else n_pass++;
    endtask

    task automatic test_random;
        int idx, d, n, df;
        for (int t = 0; t < 8; t++) begin
            d = t % 2;
            n = $urandom_range(1, 80);
            rand_frame(n);
            idx = nfr[d];
            send_frame(d, -1);
            vin[d] = 1'b0;
            wait_frames(d, idx + 1);
            build_expected(d == 1);
            df = frame_diff(d, idx);
            $display("frame dut%0d random %0d bytes len=%0d", d, n, flen[d][idx]);
            n_checks++;
            if (df != -1 || fer[d][idx] != 0)
                $display("FAIL random_frame dut%0d n=%0d: diff at %0d (len %0d, want %0d), er=%0d",
                         d, n, df, flen[d][idx], exp_q.size(), fer[d][idx]);
            else n_pass++;
        end
    endtask

    task automatic test_underrun;
        int idx, d0, u0, g0, df;
        rand_frame(30);
        idx = nfr[1];
        d0 = done_cnt[1];
        u0 = und_cnt[1];
        send_frame(1, 20);
        wait_frames(1, idx + 1);
        build_expected(1'b1);
        while (exp_q.size() > 56) void'(exp_q.pop_back());
        exp_q.push_back(4'h0);
        df = frame_diff(1, idx);
        $display("frame dut1 underrun at byte 20 len=%0d", flen[1][idx]);
        n_checks++;
        if (df != -1) $display("FAIL underrun_stream: diff at %0d, len %0d want 57", df, flen[1][idx]);
        else n_pass++;
        n_checks++;
        if (fer[1][idx] != 1) $display("FAIL underrun_er: got %0d er cycles, want 1", fer[1][idx]);
        else n_pass++;
        n_checks++;
        if (und_cnt[1] - u0 != 1 || done_cnt[1] - d0 != 0)
            $display("FAIL underrun_pulses: got und=%0d done=%0d, want und=1 done=0",
                     und_cnt[1] - u0, done_cnt[1] - d0);
        else n_pass++;
        g0 = ngap[1];
        rand_frame(3);
        send_frame(1, -1);
        vin[1] = 1'b0;
        wait_frames(1, idx + 2);
        n_checks++;
        if (ngap[1] <= g0 || gap[1][g0] != IFG + 1)
            $display("FAIL underrun_ifg: got gap %0d, want %0d", gap[1][g0], IFG + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] pool[3][64];
        int nl[3];
        int idx, g0, df;
        idx = nfr[0];
        g0 = ngap[0];
        for (int f = 0; f < 3; f++) begin
            nl[f] = $urandom_range(5, 20);
            for (int i = 0; i < nl[f]; i++) pool[f][i] = 8'($urandom);
        end
        for (int f = 0; f < 3; f++) begin
            fr.delete();
            for (int i = 0; i < nl[f]; i++) fr.push_back(pool[f][i]);
            send_frame(0, -1);
        end
        vin[0] = 1'b0;
        wait_frames(0, idx + 3);
        for (int f = 0; f < 3; f++) begin
            fr.delete();
            for (int i = 0; i < nl[f]; i++) fr.push_back(pool[f][i]);
            build_expected(1'b0);
            df = frame_diff(0, idx + f);
            $display("frame dut0 back-to-back #%0d %0d bytes len=%0d", f, nl[f], flen[0][idx + f]);
            n_checks++;
            if (df != -1) $display("FAIL b2b_stream #%0d: diff at nibble %0d", f, df);
            else n_pass++;
        end
        for (int f = 1; f < 3; f++) begin
            n_checks++;
            if (gap[0][g0 + f] != IFG + 1)
                $display("FAIL b2b_gap #%0d: got %0d low cycles, want %0d", f, gap[0][g0 + f], IFG + 1);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0, u0, idx;
        d0 = done_cnt[1];
        u0 = und_cnt[1];
        idx = nfr[1];
        vin[1] = 1'b1;
        lin[1] = 1'b0;
        din[1] = 8'h5A;
        repeat (40) @(posedge clk);
        #7;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({en[1], er[1], txd[1]} !== 6'h00)
            $display("FAIL midreset_outputs: got en=%b er=%b txd=%h, want 0", en[1], er[1], txd[1]);
        else n_pass++;
        vin[1] = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rdy[1] !== 1'b1) $display("FAIL midreset_ready: got %b, want 1", rdy[1]);
        else n_pass++;
        repeat (30) @(posedge clk);
        #1;
        $display("frame dut1 truncated by reset len=%0d", flen[1][idx]);
        n_checks++;
        if (done_cnt[1] != d0 || und_cnt[1] != u0 || nfr[1] != idx + 1 || fer[1][idx] != 0)
            $display("FAIL midreset_pulses: got done=%0d und=%0d frames=%0d er=%0d, want 0 0 1 0",
                     done_cnt[1] - d0, und_cnt[1] - u0, nfr[1] - idx, fer[1][idx]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_pad();
        test_single_byte();
        test_random();
        test_underrun();
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (tmo != 0) $display("FAIL timeouts: got %0d expired waits, want 0", tmo);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
